// File: rtl/pool_1.sv
// Binary 2x2 pooling reader: scans the conv_1 sign maps window by window and streams one bit per window.
// Optional macro POOL1_MAJORITY_EN selects majority (>=2 of 4) instead of OR reduction.
module pool_1 #(
  parameter int FMAP_W     = 24,
  parameter int KERNAL_NUM = 6,
  parameter int RD_LAT     = 1,
  parameter int AW         = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          wr_data
);

  localparam int P  = FMAP_W / 2;
  localparam int CW = $clog2(P + 1);
  localparam int KW = $clog2(KERNAL_NUM + 1);
  localparam logic [CW-1:0] PC_LAST = CW'(P - 1);
  localparam logic [KW-1:0] K_LAST  = KW'(KERNAL_NUM - 1);
  localparam logic [1:0]    W_LAST  = 2'(RD_LAT - 1);
  localparam logic [AW-1:0] ROW     = AW'(FMAP_W);
  localparam logic [AW-1:0] STEP    = AW'(2);
  // Moving past the last column of a window row (or map) lands exactly one row plus two further on.
  localparam logic [AW-1:0] WRAP    = AW'(FMAP_W + 2);

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

  state_t          state_q, state_d;
  logic            dx_q, dx_d, dy_q, dy_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic [CW-1:0]   pc_q, pc_d, pr_q, pr_d;
  logic [KW-1:0]   k_q, k_d;
  logic [AW-1:0]   base_q, base_d, widx_q, widx_d;
  logic [2:0]      cnt_q, cnt_d, cnt_base;
  logic [RD_LAT-1:0] vld_q;
  logic            busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic            wr_en_q, wr_en_d, wr_data_q, wr_data_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic            hit, last_win;

  function automatic logic reduce_bits(input logic [2:0] ones);
`ifdef POOL1_MAJORITY_EN
    return ones >= 3'd2;
`else
    return ones != 3'd0;
`endif
  endfunction

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  assign last_win = (pc_q == PC_LAST) && (pr_q == PC_LAST) && (k_q == K_LAST);

  always_comb begin
    state_d   = state_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    wcnt_d    = wcnt_q;
    pc_d      = pc_q;
    pr_d      = pr_q;
    k_d       = k_q;
    base_d    = base_q;
    widx_d    = widx_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // Ones counter restarts on each window's first read; no data can arrive in that cycle.
    hit      = vld_q[RD_LAT-1] & rd_data;
    cnt_base = (state_q == READ && !dx_q && !dy_q) ? 3'd0 : cnt_q;
    cnt_d    = cnt_base + {2'b00, hit};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          dx_d      = 1'b0;
          dy_d      = 1'b0;
          pc_d      = '0;
          pr_d      = '0;
          k_d       = '0;
          base_d    = '0;
          widx_d    = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      READ: begin
        if (dx_q && dy_q) begin
          state_d = WAIT;
          wcnt_d  = 2'd0;
        end else begin
          dx_d      = ~dx_q;
          dy_d      = dy_q | dx_q;
          rd_en_d   = 1'b1;
          rd_addr_d = base_q + (dy_d ? ROW : '0) + {{(AW-1){1'b0}}, dx_d};
        end
      end
      WAIT: begin
        if (wcnt_q == W_LAST) begin
          state_d   = WRITE;
          wr_en_d   = 1'b1;
          wr_data_d = reduce_bits(cnt_d);
          wr_addr_d = widx_q;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      WRITE: begin
        widx_d = widx_q + {{(AW-1){1'b0}}, 1'b1};
        if (last_win) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = READ;
          dx_d    = 1'b0;
          dy_d    = 1'b0;
          base_d  = base_q + ((pc_q == PC_LAST) ? WRAP : STEP);
          if (pc_q == PC_LAST) begin
            pc_d = '0;
            if (pr_q == PC_LAST) begin
              pr_d = '0;
              k_d  = k_q + {{(KW-1){1'b0}}, 1'b1};
            end else begin
              pr_d = pr_q + {{(CW-1){1'b0}}, 1'b1};
            end
          end else begin
            pc_d = pc_q + {{(CW-1){1'b0}}, 1'b1};
          end
          rd_en_d   = 1'b1;
          rd_addr_d = base_d;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dx_q      <= 1'b0;
      dy_q      <= 1'b0;
      wcnt_q    <= '0;
      pc_q      <= '0;
      pr_q      <= '0;
      k_q       <= '0;
      base_q    <= '0;
      widx_q    <= '0;
      cnt_q     <= '0;
      vld_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      wcnt_q    <= wcnt_d;
      pc_q      <= pc_d;
      pr_q      <= pr_d;
      k_q       <= k_d;
      base_q    <= base_d;
      widx_q    <= widx_d;
      cnt_q     <= cnt_d;
      // Delay line marks the cycle in which each issued read returns its bit.
      vld_q[0]  <= rd_en_q;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: doc/pool_1.md
# pool_1

Binary 2x2 max-pooling reader for the first feature-map RAM (poor_1). After the first convolution stage has finished writing all kernels' 1-bit, 24x24 sign maps, this block reads them back window by window and reduces each 2x2 window to one bit. It streams the 12x12 pooled maps into the next-stage RAM through a simple write port. It sits between the conv_1 output RAM and the second convolution stage.

## Interface
Parameters:
- FMAP_W, 24: input map side; must be even.
- KERNAL_NUM, 6: number of maps stored back to back.
- RD_LAT, 1: RAM read latency in cycles, 1..3.
- AW, 15: address width of both RAM ports.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse from the conv stage meaning all maps are written.
- busy, output, 1: high from the cycle after an accepted start until done.
- done, output, 1: one-cycle pulse after the last write.
- rd_en, output, 1: read strobe to the poor_1 RAM.
- rd_addr, output, AW: read address.
- rd_data, input, 1: RAM data, valid RD_LAT cycles after rd_en.
- wr_en, output, 1: write strobe to the pooled-map RAM.
- wr_addr, output, AW: write address.
- wr_data, output, 1: pooled bit.

## Operation
- Input layout: the bit for map k, row r, column c is at address k·FMAP_W² + r·FMAP_W + c.
- Output layout: the bit for map k, pooled row pr, pooled column pc is at address k·P² + pr·P + pc, where P = FMAP_W/2.
- Scan order is map-major, then pr, then pc, so wr_addr increments by exactly 1 per window, starting at 0.
- State machine states: IDLE, READ, WAIT, WRITE.
- IDLE goes to READ on start. All other states ignore start.
- READ lasts 4 cycles with rd_en=1. The addresses issued are, in order, (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc) and (2pr+1,2pc+1).
- WAIT lasts RD_LAT cycles. rd_en=0 during WAIT.
- WRITE lasts 1 cycle with wr_en=1. After WRITE the block returns to READ for the next window. After the last window it goes to IDLE with done=1.
- Accumulation: a 3-bit ones counter clears at the first READ cycle of each window. It counts each rd_data bit that arrives RD_LAT cycles after its rd_en.
- Reduction: wr_data is 1 if the count is ≥1 (logical OR). See Configuration for the alternative.
- Address generation uses incremental counters (k, pr, pc, dy, dx); no multipliers.
- Wrap-around: pc wraps at P-1 into pr, pr wraps at P-1 into k, and k at KERNAL_NUM-1 ends the run.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0. The state is IDLE and all counters are 0.
- Asynchronous reset mid-run aborts immediately. No further writes are issued and done is not pulsed. A start after reset release begins again from window 0.
- Cycle numbering: start is sampled at edge 0. The first READ cycle is cycle 1 and busy rises in cycle 1.
- Each window takes 5+RD_LAT cycles. For the defaults that is 6 cycles: reads in cycles 1–4, WAIT in cycle 5, write in cycle 6.
- Total run: the last write occurs at cycle KERNAL_NUM·P²·(5+RD_LAT), which is 5184 for the defaults.
- done is high in the following cycle, busy falls in that same cycle, and the block is back in IDLE.
- start asserted while busy=1 is dropped, with no queueing.
- start in the same cycle as done is accepted (the block is in IDLE).
- wr_addr, wr_data and wr_en are registered and change together.
- rd_addr is held at its last value while rd_en=0.

## Configuration
- POOL1_MAJORITY_EN defined: wr_data = 1 when the ones count is ≥2 (majority-style binary average pooling). Ties (2 of 4) give 1.
- POOL1_MAJORITY_EN undefined: wr_data = OR of the four bits (max pooling).
- The macro changes nothing else: cycle timing and addresses are identical in both builds.

## Test plan
- All-zero map, default parameters, start at cycle 0: 864 writes, wr_addr 0..863, all wr_data=0. done is high at cycle 5185 and busy is low from cycle 5185.
- Address check, first window: rd_addr is 0, 1, 24, 25 in cycles 1–4 and wr_addr=0 at cycle 6. Last window: rd_addr is 3430, 3431, 3454, 3455 and wr_addr=863.
- A single 1 at address 25, rest 0: wr_addr 0 gets wr_data=1 in the OR build and 0 in the majority build. Bits at 0 and 25 set: 1 in both builds.
- RD_LAT=3, all-ones map: every wr_data=1, each window takes 8 cycles, and done is high at cycle 6913.
- start pulsed again at cycle 100 while busy: ignored. The write count stays at 864 and there is exactly one done pulse.
- rst_n low at cycle 3000: all outputs are 0 at once and no done pulse occurs. A restart then produces wr_addr starting again at 0.
